alu_req_sched: RTL and testbench

- Two-requester scheduler sharing one combinational `alu` instance (4-bit op, 32-bit A/B, 32-bit out).
- Accepts operations over valid/ready, arbitrates round-robin and drives the ALU from registered operands.
- Captures the result and returns it with the requester ID over a valid/ready response channel.
- Sits between the control/issue logic and the single ALU datapath; one operation in flight at a time.

---
 rtl/alu_req_sched_pkg.sv | 9 +
 rtl/alu_req_sched_if.sv | 16 +
 rtl/rr_arb2.sv | 12 +
 rtl/alu_req_sched.sv | 110 +++++++++++
 tb/tb_alu_req_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_req_sched_pkg.sv
// alu_req_sched_pkg: shared widths, ALU opcode range and scheduler state encoding.
package alu_req_sched_pkg;
  localparam int DATA_W = 32;
  localparam int OP_W = 4;
  localparam int ALU_DATA_W = DATA_W;
  localparam int ALU_OP_W = OP_W;
  localparam logic [OP_W-1:0] ALU_NUM_OPS = 4'd8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_e;
endpackage

// File: rtl/alu_req_sched_if.sv
// alu_req_sched_if: request channels, ALU drive and response channel of the scheduler.
interface alu_req_sched_if;
  import alu_req_sched_pkg::*;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OP_W-1:0] req0_op, req1_op, alu_ctrl;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, alu_out, rsp_ready,
    input  req0_ready, req1_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter; the last-grant state lives in the caller.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_id
);
  assign grant_id = (valid0 & valid1) ? ~last_grant : valid1;
  assign grant = (en & (valid0 | valid1)) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_req_sched.sv
// alu_req_sched: two-requester round-robin scheduler for one shared ALU; ALU_REQ_SCHED_OPCHK_EN rejects opcodes >= ALU_NUM_OPS.
module alu_req_sched
  import alu_req_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_req_sched_if.slave bus
);
  state_e state_q, state_d;
  logic [OP_W-1:0] alu_ctrl_q, alu_ctrl_d, op_sel;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d, a_sel, b_sel;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic last_grant_q, last_grant_d, id_q, id_d, bad_q, bad_d;
  logic [1:0] grant;
  logic grant_id, bad_op;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .en         (state_q == S_IDLE),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign op_sel = grant_id ? bus.req1_op : bus.req0_op;
  assign a_sel  = grant_id ? bus.req1_a  : bus.req0_a;
  assign b_sel  = grant_id ? bus.req1_b  : bus.req0_b;
`ifdef ALU_REQ_SCHED_OPCHK_EN
  assign bad_op = op_sel >= ALU_NUM_OPS;
`else
  assign bad_op = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    bad_d        = bad_q;
    case (state_q)
      S_IDLE: if (|grant) begin
        state_d      = S_EXEC;
        id_d         = grant_id;
        last_grant_d = grant_id;
        bad_d        = bad_op;
        // A rejected opcode leaves the ALU inputs untouched
        alu_ctrl_d   = bad_op ? alu_ctrl_q : op_sel;
        alu_a_d      = bad_op ? alu_a_q : a_sel;
        alu_b_d      = bad_op ? alu_b_q : b_sel;
      end
      S_EXEC: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = bad_q;
        rsp_data_d  = bad_q ? '0 : bus.alu_out;
      end
      S_RESP: if (bus.rsp_ready) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      bad_q        <= bad_d;
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched: directed checks of latency, opcode pass-through, fairness, backpressure, reset and opcode rejection.
module tb_alu_req_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  alu_req_sched_if bus ();

  alu_req_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'd0, $signed(a) < $signed(b)};
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      default: return 32'hDEAD_0000 | {28'd0, op};
    endcase
  endfunction

  assign bus.alu_out = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit r, input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (r) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic issue(input bit r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    drive_req(r, 1'b1, op, a, b);
    #1;
    while (!(r ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    drive_req(r, 1'b0, op, a, b);
  endtask

  task automatic collect(input string tag, input logic id, input logic [31:0] data, input logic err);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_wait"}, 32'(n < 20), 32'd1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_data"}, bus.rsp_data, data);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 32'(bus.alu_ctrl), 32'd0);
    check({tag, "_a"}, bus.alu_a, 32'd0);
    check({tag, "_b"}, bus.alu_b, 32'd0);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_data"}, bus.rsp_data, 32'd0);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sweep_exp [8];
    int g, n;
    sweep_exp = '{32'd383, 32'd125, 32'd128, 32'd255, 32'd127, 32'd0, 32'd508, 32'd127};
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single request latency
    drive_req(1'b0, 1'b1, 4'd0, 32'd254, 32'd129);
    #1;
    check("t1_rdy0", 32'(bus.req0_ready), 32'd1);
    check("t1_rdy1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 4'd0, 32'd254, 32'd129);
    check("t1_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("t1_a", bus.alu_a, 32'd254);
    check("t1_b", bus.alu_b, 32'd129);
    check("t1_exec_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    collect("t1", 1'b0, 32'd383, 1'b0);

    // opcode sweep on requester 1
    for (int op = 0; op < 8; op++) begin
      issue(1'b1, 4'(op), 32'd254, 32'd129);
      check($sformatf("sweep%0d_ctrl", op), 32'(bus.alu_ctrl), 32'(op));
      collect($sformatf("sweep%0d", op), 1'b1, sweep_exp[op], 1'b0);
    end

    // contention fairness
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 4'd0, 32'd1, 32'd0);
    drive_req(1'b1, 1'b1, 4'd0, 32'd2, 32'd0);
    g = 0;
    n = 0;
    while (g < 6 && n < 60) begin
      #1; n++;
      check("dual_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      if (bus.req0_ready | bus.req1_ready) begin
        check($sformatf("grant%0d", g), 32'(bus.req1_ready), 32'(g % 2));
        g++;
      end
      @(posedge clk); #1;
    end
    check("contention_grants", 32'(g), 32'd6);
    drive_req(1'b0, 1'b0, 4'd0, 32'd1, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd2, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;

    // response backpressure
    issue(1'b0, 4'd2, 32'd254, 32'd129);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 4'd3, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_data", i), bus.rsp_data, 32'd128);
      check($sformatf("bp%0d_id", i), 32'(bus.rsp_id), 32'd0);
      check($sformatf("bp%0d_rdy", i), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_rdy1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 4'd3, 32'd1, 32'd2);
    check("bp_next_a", bus.alu_a, 32'd1);
    check("bp_next_ctrl", 32'(bus.alu_ctrl), 32'd3);
    collect("bp2", 1'b1, 32'd3, 1'b0);

    // reset during EXEC
    issue(1'b1, 4'd1, 32'd7, 32'd3);
    check("mid_exec_ctrl", 32'(bus.alu_ctrl), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk); #1;
    check("mid_rst_hold", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_req(1'b0, 1'b1, 4'd4, 32'd254, 32'd129);
    drive_req(1'b1, 1'b1, 4'd1, 32'd7, 32'd3);
    #1;
    check("post_rst_rdy0", 32'(bus.req0_ready), 32'd1);
    check("post_rst_rdy1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 4'd4, 32'd254, 32'd129);
    drive_req(1'b1, 1'b0, 4'd1, 32'd7, 32'd3);
    collect("post_rst", 1'b0, 32'd127, 1'b0);

    // out-of-range opcode
    issue(1'b0, 4'd9, 32'd5, 32'd5);
`ifdef ALU_REQ_SCHED_OPCHK_EN
    check("op9_ctrl", 32'(bus.alu_ctrl), 32'd4);
    check("op9_a", bus.alu_a, 32'd254);
    collect("op9", 1'b0, 32'd0, 1'b1);
`else
    check("op9_ctrl", 32'(bus.alu_ctrl), 32'd9);
    check("op9_a", bus.alu_a, 32'd5);
    collect("op9", 1'b0, 32'hDEAD_0009, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
